// File: rtl/wb_stage_pipe_reg.sv
// ALU-to-writeback pipeline register with a valid/ready handshake.
// A 2-entry skid buffer (main = head, skid = younger) keeps in_ready a pure
// decode of the state register. The stage also supports flush and has a
// saturating stall counter.
// Optional feature: define STAGE_FWD_EN to enable forwarding lookups on
// fwd_sel. Without it, fwd_hit and fwd_data are tied to 0.
module wb_stage_pipe_reg #(
  parameter int DATA_W      = 32,
  parameter int SEL_W       = 5,
  parameter bit SUPPRESS_R0 = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_we,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic [SEL_W-1:0]  fwd_sel,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]    main_sel_q,  main_sel_d;
  logic                main_we_q,   main_we_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]    skid_sel_q,  skid_sel_d;
  logic                skid_we_q,   skid_we_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic accept_in;
  logic accept_out;
  logic in_we_eff;

  assign in_ready   = (state_q != TWO);
  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_data_q;
  assign out_sel    = main_sel_q;
  assign out_we     = main_we_q;
  assign stall_cnt  = stall_cnt_q;

  assign accept_in  = in_valid & in_ready;
  assign accept_out = out_valid & out_ready;

  // Writes to r0 still flow through the stage, but with their enable dropped.
  assign in_we_eff  = in_we & ~(SUPPRESS_R0 && (in_sel == '0));

  // Next-state and entry-movement logic. Flush overrides the handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_we_d   = main_we_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_we_d   = skid_we_q;
    if (flush) begin
      state_d     = EMPTY;
      main_data_d = '0;
      main_sel_d  = '0;
      main_we_d   = 1'b0;
      skid_data_d = '0;
      skid_sel_d  = '0;
      skid_we_d   = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_in) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_sel_d  = in_sel;
            main_we_d   = in_we_eff;
          end
        end
        ONE: begin
          if (accept_in && accept_out) begin
            main_data_d = in_data;
            main_sel_d  = in_sel;
            main_we_d   = in_we_eff;
          end else if (accept_in) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_sel_d  = in_sel;
            skid_we_d   = in_we_eff;
          end else if (accept_out) begin
            state_d     = EMPTY;
          end
        end
        TWO: begin
          if (accept_out) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
            main_we_d   = skid_we_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Stall counter saturates at all-ones and is unaffected by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State, entry, and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_we_q   <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_we_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_we_q   <= main_we_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_we_q   <= skid_we_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef STAGE_FWD_EN
  logic skid_match;
  logic main_match;
  logic fwd_allowed;

  assign fwd_allowed = ~(SUPPRESS_R0 && (fwd_sel == '0));
  assign skid_match  = (state_q == TWO) && skid_we_q && (skid_sel_q == fwd_sel);
  assign main_match  = (state_q != EMPTY) && main_we_q && (main_sel_q == fwd_sel);

  // The younger skid entry takes precedence over the head.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_allowed) begin
      if (skid_match) begin
        fwd_hit  = 1'b1;
        fwd_data = skid_data_q;
      end else if (main_match) begin
        fwd_hit  = 1'b1;
        fwd_data = main_data_q;
      end
    end
  end
`else
  logic unused_fwd_sel;

  assign unused_fwd_sel = ^fwd_sel;
  assign fwd_hit        = 1'b0;
  assign fwd_data       = '0;
`endif

endmodule

// File: tb/tb_wb_stage_pipe_reg.sv
// Directed testbench for wb_stage_pipe_reg. CNT_W is reduced to 3 so that
// stall counter saturation can be reached quickly.
module tb_wb_stage_pipe_reg;

  localparam int DATA_W = 32;
  localparam int SEL_W  = 5;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_we;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_we;
  logic [CNT_W-1:0]  stall_cnt;
  logic [SEL_W-1:0]  fwd_sel;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  int n_chk;
  int n_pass;

  wb_stage_pipe_reg #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .SUPPRESS_R0(1'b1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_we(out_we),
    .stall_cnt(stall_cnt),
    .fwd_sel(fwd_sel), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [SEL_W-1:0] s, input logic we);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    in_we    = we;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0; fwd_sel = '0;
    drive(1'b0, '0, '0, 1'b0);
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready, 1);
    chk("rst_stall",     stall_cnt, 0);
    chk("rst_out_data",  out_data, 0);

    // Single entry, 1-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 5'd3, 1'b1);
    step();
    chk("t2_valid", out_valid, 1);
    chk("t2_data",  out_data, 64'hDEADBEEF);
    chk("t2_sel",   out_sel, 3);
    chk("t2_we",    out_we, 1);
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("t2_drain", out_valid, 0);

    // Streaming 8 entries on consecutive cycles
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + i, 5'(i + 1), 1'b1);
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data",  out_data, 64'h100 + i);
      chk("stream_rdy",   in_ready, 1);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("stream_end", out_valid, 0);

    // Backpressure: fill both entries
    out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 1'b1);
    step();
    chk("bp_a_rdy", in_ready, 1);
    chk("bp_stall0", stall_cnt, 0);
    drive(1'b1, 32'h22, 5'd2, 1'b1);
    step();
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_head_a",  out_data, 64'h11);
    chk("bp_stall1",  stall_cnt, 1);
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("bp_hold_a",  out_data, 64'h11);
    chk("bp_hold_sel", out_sel, 1);
    chk("bp_stall2",  stall_cnt, 2);
    out_ready = 1'b1;
    step();
    chk("bp_head_b",  out_data, 64'h22);
    chk("bp_rdy_back", in_ready, 1);
    chk("bp_stall_hold", stall_cnt, 2);
    step();
    chk("bp_empty", out_valid, 0);

    // r0 write suppression
    drive(1'b1, 32'h55, 5'd0, 1'b1);
    step();
    chk("r0_valid", out_valid, 1);
    chk("r0_we",    out_we, 0);
    chk("r0_data",  out_data, 64'h55);
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("r0_drain", out_valid, 0);

    // Flush while full, with in_valid high
    out_ready = 1'b0;
    drive(1'b1, 32'h66, 5'd4, 1'b1);
    step();
    drive(1'b1, 32'h77, 5'd5, 1'b1);
    step();
    chk("fl_full", in_ready, 0);
    chk("fl_stall3", stall_cnt, 3);
    flush = 1'b1;
    drive(1'b1, 32'h99, 5'd6, 1'b1);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_rdy",   in_ready, 1);
    chk("fl_data",  out_data, 0);
    chk("fl_we",    out_we, 0);
    chk("fl_stall4", stall_cnt, 4);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("fl_nocap", out_valid, 0);

    // Forwarding with both entries holding sel 7
    drive(1'b1, 32'hA, 5'd7, 1'b1);
    step();
    drive(1'b1, 32'hB, 5'd7, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    chk("fw_stall5", stall_cnt, 5);
    fwd_sel = 5'd7;
    #1;
`ifdef STAGE_FWD_EN
    chk("fw_hit",  fwd_hit, 1);
    chk("fw_data", fwd_data, 64'hB);
`else
    chk("fw_hit_off",  fwd_hit, 0);
    chk("fw_data_off", fwd_data, 0);
`endif
    fwd_sel = 5'd3;
    #1;
    chk("fw_miss", fwd_hit, 0);

    // Saturation of the stall counter
    step(); step(); step(); step();
    chk("sat_stall", stall_cnt, 7);
    chk("sat_head",  out_data, 64'hA);
    out_ready = 1'b1;
    step();
    chk("sat_head_b", out_data, 64'hB);
    step();
    chk("sat_empty", out_valid, 0);
    chk("sat_hold",  stall_cnt, 7);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_stall", stall_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
